// File: rtl/uart_input_if.sv
// Receive-side bundle of the 8N1 serial receiver: serial line in, byte/status out.
// UART_RX_PARITY_EN adds the parity_error status bit.
interface uart_input_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_error;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif
  logic [2:0] state_dbg;

  // Producer side (the receiver): consumes rx, drives byte and status.
  // data_valid is a one-cycle strobe with no ready; the consumer must take data_out that cycle.
  modport master (
    input  rx,
    output data_out, data_valid, busy, frame_error,
`ifdef UART_RX_PARITY_EN
    parity_error,
`endif
    state_dbg
  );

  modport slave (
    output rx,
    input  data_out, data_valid, busy, frame_error,
`ifdef UART_RX_PARITY_EN
    parity_error,
`endif
    state_dbg
  );
endinterface

// File: rtl/uart_input.sv
// 8N1 serial receiver, LSB first, mid-bit sampling on a 2-flop synchronised rx.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error strobe.
module uart_input #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 10
) (
  input  logic          clk,
  input  logic          reset,
  uart_input_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic             rx_m_q, rx_m_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_error_q, frame_error_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_error_q, parity_error_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rx_m_q        <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      fall_q        <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rx_m_q        <= rx_m_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      fall_q        <= fall_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= par_bit_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  always_comb begin
    rx_m_d        = bus.rx;
    rx_s_d        = rx_m_q;
    rx_prev_d     = rx_s_q;
    // Registered falling edge: start detection lags rx_s by one clk.
    fall_d        = rx_prev_q & ~rx_s_q;
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = frame_error_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d      = par_bit_q;
    parity_error_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_q) begin
          state_d       = S_START;
          frame_error_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_error_d = ^{shift_q, par_bit_q};
`endif
            state_d = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.frame_error = frame_error_q;
  assign bus.state_dbg   = state_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_input.sv
// Directed bench for uart_input at 16 clk per bit: table of frames plus
// glitch, back-to-back, mid-frame reset and (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_input;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT = (FRAME_BITS - 1) * CPB + CPB / 2 + 4;
  localparam int NV  = 7;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   strobe_cyc[0:63];
  logic [8:0] exp_q[$];
  vec_t vec[NV];

  uart_input_if bus();

  uart_input #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every data_valid strobe must match the head of exp_q.
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (reset && bus.data_valid) begin
      strobe_cyc[strobe_cnt % 64] = cyc;
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got data %0h expected no strobe", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        check("strobe_data", 32'(bus.data_out), 32'(e[7:0]));
`ifdef UART_RX_PARITY_EN
        check("strobe_parity_error", 32'(bus.parity_error), 32'(e[8]));
`endif
        check("busy_at_strobe", 32'(bus.busy), 32'd0);
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_clks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    logic [10:0] bits_p;
    logic [10:0] bits_n;
    logic [10:0] bits;
    bits_p = {stop, par, data, 1'b0};
    bits_n = {1'b1, stop, data, 1'b0};
    bits   = (FRAME_BITS == 11) ? bits_p : bits_n;
    for (int i = 0; i < FRAME_BITS; i++) send_bit(bits[i]);
    bus.rx = 1'b1;
  endtask

  initial begin : stim
    int base;
    int t0;
    int lat;
    logic [7:0] c3;

    vec[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vec[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1};
    vec[2] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};
    vec[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vec[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vec[5] = '{8'h81, 1'b0, 1'b0, 8'hFF, 1'b1};
    vec[6] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b0};

    // Reset state
    bus.rx = 1'b1;
    wait_clks(3);
    @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_error", 32'(bus.frame_error), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_clks(4);

    // Table-driven frames, each followed by 32 idle clocks
    for (int i = 0; i < NV; i++) begin
      base = strobe_cnt;
      if (vec[i].exp_valid) exp_q.push_back({1'b0, vec[i].data});
      send_frame(vec[i].data, ^vec[i].data, vec[i].stop);
      wait_clks(32);
      @(negedge clk);
      check($sformatf("vec%0d_data_out", i), 32'(bus.data_out), 32'(vec[i].exp_dout));
      check($sformatf("vec%0d_frame_error", i), 32'(bus.frame_error), 32'(vec[i].exp_ferr));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
      check($sformatf("vec%0d_strobes", i), 32'(strobe_cnt - base), 32'(vec[i].exp_valid));
    end

    // Glitch: rx low for 5 clk is rejected at the mid-start sample
    base = strobe_cnt;
    wait_clks(1);
    bus.rx = 1'b0;
    wait_clks(4);
    @(negedge clk);
    check("glitch_busy_high", 32'(bus.busy), 32'd1);
    wait_clks(1);
    bus.rx = 1'b1;
    wait_clks(10);
    @(negedge clk);
    check("glitch_busy_low", 32'(bus.busy), 32'd0);
    check("glitch_strobes", 32'(strobe_cnt - base), 32'd0);
    check("glitch_data_out", 32'(bus.data_out), 32'h7E);

    // Back-to-back frames: latency and spacing
    base = strobe_cnt;
    wait_clks(1);
    t0 = cyc;
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    wait_clks(32);
    @(negedge clk);
    check("b2b_strobes", 32'(strobe_cnt - base), 32'd3);
    if (strobe_cnt - base == 3) begin
      lat = strobe_cyc[base % 64] - t0;
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        errors++;
        $display("FAIL b2b_latency: got %0d expected %0d +/-1", lat, LAT);
      end
      check("b2b_gap1", 32'(strobe_cyc[(base + 1) % 64] - strobe_cyc[base % 64]), 32'(FRAME_BITS * CPB));
      check("b2b_gap2", 32'(strobe_cyc[(base + 2) % 64] - strobe_cyc[(base + 1) % 64]), 32'(FRAME_BITS * CPB));
    end

    // Reset in the middle of bit 4 of 0xC3, then 0x11
    base = strobe_cnt;
    c3 = 8'hC3;
    wait_clks(1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    bus.rx = c3[4];
    wait_clks(8);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_data_valid", 32'(bus.data_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_frame_error", 32'(bus.frame_error), 32'd0);
    wait_clks(2);
    bus.rx = 1'b1;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(32);
    @(negedge clk);
    check("midrst_no_strobe", 32'(strobe_cnt - base), 32'd0);
    check("midrst_busy_after", 32'(bus.busy), 32'd0);
    exp_q.push_back({1'b0, 8'h11});
    wait_clks(1);
    send_frame(8'h11, 1'b0, 1'b1);
    wait_clks(32);
    @(negedge clk);
    check("post_rst_data_out", 32'(bus.data_out), 32'h11);
    check("post_rst_strobes", 32'(strobe_cnt - base), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, 1 is right
    base = strobe_cnt;
    exp_q.push_back({1'b1, 8'h07});
    wait_clks(1);
    send_frame(8'h07, 1'b0, 1'b1);
    wait_clks(32);
    exp_q.push_back({1'b0, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(32);
    @(negedge clk);
    check("parity_strobes", 32'(strobe_cnt - base), 32'd2);
    check("parity_data_out", 32'(bus.data_out), 32'h07);
    check("parity_err_cleared", 32'(bus.parity_error), 32'd0);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
